// File: rtl/byte_lane_mem_adaptor.sv
// Byte-wide read/write front end for a 32-bit word SDRAM controller.
// Byte writes are read-modify-write; CLEAR zero-fills the whole word range.
module byte_lane_mem_adaptor #(
    parameter int LOGSIZE        = 10,
    parameter int SETTLE         = 50,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [56:0]        memOut,
    input  logic [33:0]        memIn,
    input  logic               init,
    input  logic [LOGSIZE-1:0] addr,
    input  logic [7:0]         wdata,
    input  logic               wselect,
    input  logic               doit,
    output logic               busy,
    output logic               rvalid,
    output logic [7:0]         rdata
);

    localparam int WW = LOGSIZE - 2;
    localparam logic [WW-1:0] WLast = {WW{1'b1}};

    localparam logic [2:0] StClear   = 3'd0;
    localparam logic [2:0] StIdle    = 3'd1;
    localparam logic [2:0] StRdIssue = 3'd2;
    localparam logic [2:0] StRdWait  = 3'd3;
    localparam logic [2:0] StWrIssue = 3'd4;
    localparam logic [2:0] StSettle  = 3'd5;

    localparam logic [2:0] StReset = CLEAR_ON_RESET ? StClear : StIdle;

    logic [2:0]         state_q, state_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    logic [6:0]         scnt_q, scnt_d;
    logic               pend_q, pend_d;
    logic [LOGSIZE-1:0] addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               wsel_q, wsel_d;
    logic [31:0]        merged_q, merged_d;
    logic               rvalid_q, rvalid_d;
    logic [7:0]         rdata_q, rdata_d;

    logic        mem_busy, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  lane_sh;
    logic [22:0] word_addr;

    assign mem_busy   = memIn[33];
    assign mem_rvalid = memIn[32];
    assign mem_rdata  = memIn[31:0];
    // Lane 0 is the most significant byte, so shift = (3 - lane) * 8.
    assign lane_sh    = {~addr_q[1:0], 3'b000};
    assign word_addr  = 23'(addr_q[LOGSIZE-1:2]);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        scnt_d   = scnt_q;
        pend_d   = pend_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wsel_d   = wsel_q;
        merged_d = merged_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        if (init && state_q != StIdle && state_q != StClear) begin
            pend_d = 1'b1;
        end
        case (state_q)
            StClear: begin
                if (!mem_busy) begin
                    if (wcnt_q == WLast) begin
                        state_d = StSettle;
                        scnt_d  = 7'(SETTLE);
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            StIdle: begin
                if (init || pend_q) begin
                    state_d = StClear;
                    wcnt_d  = '0;
                    pend_d  = 1'b0;
                end else if (doit) begin
                    state_d = StRdIssue;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wsel_d  = wselect;
                end
            end
            StRdIssue: begin
                if (!mem_busy) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (mem_rvalid) begin
                    if (wsel_q) begin
                        merged_d = (mem_rdata & ~(32'hFF << lane_sh))
                                 | ({24'h0, wdata_q} << lane_sh);
                        state_d  = StWrIssue;
                    end else begin
                        rdata_d  = 8'(mem_rdata >> lane_sh);
                        rvalid_d = 1'b1;
                        state_d  = StSettle;
                        scnt_d   = 7'(SETTLE);
                    end
                end
            end
            StWrIssue: begin
                if (!mem_busy) begin
                    state_d = StSettle;
                    scnt_d  = 7'(SETTLE);
                end
            end
            StSettle: begin
                if (scnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StReset;
            wcnt_q   <= '0;
            scnt_q   <= '0;
            pend_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wsel_q   <= 1'b0;
            merged_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            scnt_q   <= scnt_d;
            pend_q   <= pend_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wsel_q   <= wsel_d;
            merged_q <= merged_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Address/data are held for the whole issue state, not only the doit cycle.
    logic        m_doit, m_wsel;
    logic [22:0] m_addr;
    logic [31:0] m_data;

    always_comb begin
        m_doit = 1'b0;
        m_wsel = 1'b0;
        m_addr = '0;
        m_data = '0;
        case (state_q)
            StClear: begin
                m_doit = !mem_busy;
                m_wsel = 1'b1;
                m_addr = 23'(wcnt_q);
            end
            StRdIssue: begin
                m_doit = !mem_busy;
                m_addr = word_addr;
            end
            StWrIssue: begin
                m_doit = !mem_busy;
                m_wsel = 1'b1;
                m_addr = word_addr;
                m_data = merged_q;
            end
            default: ;
        endcase
        if (reset) begin
            m_doit = 1'b0;
            m_wsel = 1'b0;
            m_addr = '0;
            m_data = '0;
        end
    end

    assign memOut = {m_wsel, m_addr, m_doit, m_data};
    assign busy   = (state_q != StIdle) || pend_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_byte_lane_mem_adaptor.sv
// Directed bench: byte-array memory model predicts SDRAM traffic and read data;
// a per-cycle compare process checks them, plus literal expectations.
module tb_byte_lane_mem_adaptor;

    localparam int LOGSIZE = 4;
    localparam int NWORDS  = 4;
    localparam int NBYTES  = 16;

    logic               clk = 1'b0;
    logic               reset, init, wselect, doit;
    logic [LOGSIZE-1:0] addr;
    logic [7:0]         wdata;
    logic               mem_busy;
    logic               mem_rvalid = 1'b0;
    logic [31:0]        mem_rdata = 32'h0;
    logic [56:0]        mem_out;
    logic [33:0]        mem_in;
    logic               busy, rvalid;
    logic [7:0]         rdata;

    assign mem_in = {mem_busy, mem_rvalid, mem_rdata};

    always #5 clk = ~clk;

    byte_lane_mem_adaptor #(
        .LOGSIZE       (LOGSIZE),
        .SETTLE        (2),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .memOut (mem_out),
        .memIn  (mem_in),
        .init   (init),
        .addr   (addr),
        .wdata  (wdata),
        .wselect(wselect),
        .doit   (doit),
        .busy   (busy),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ops_seen = 0;
    int rv_seen  = 0;
    logic [7:0]  last_rdata = 8'h00;
    logic [7:0]  model_b [NBYTES];
    logic [55:0] exp_ops [$];
    logic [7:0]  exp_rd  [$];
    logic [31:0] sdram   [NWORDS];
    int          rd_cnt = 0;
    logic [22:0] rd_word = '0;

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {model_b[4*w], model_b[4*w+1], model_b[4*w+2], model_b[4*w+3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) fail("idle_timeout", n, 0);
    endtask

    task automatic push_clear();
        for (int w = 0; w < NWORDS; w++) exp_ops.push_back({1'b1, 23'(w), 32'h0});
        for (int b = 0; b < NBYTES; b++) model_b[b] = 8'h00;
    endtask

    task automatic req(input logic [LOGSIZE-1:0] a, input logic ws, input logic [7:0] d);
        int w;
        int n;
        w = int'(a) / 4;
        exp_ops.push_back({1'b0, 23'(w), 32'h0});
        if (ws) begin
            model_b[a] = d;
            exp_ops.push_back({1'b1, 23'(w), model_word(w)});
        end else begin
            exp_rd.push_back(model_b[a]);
        end
        wait_idle(n);
        addr    = a;
        wselect = ws;
        wdata   = d;
        doit    = 1'b1;
        step();
        doit    = 1'b0;
    endtask

    // Compare process: every SDRAM op and every rvalid against the model.
    always @(negedge clk) begin
        logic [55:0] e, act;
        if (reset) begin
            check("reset_memout", mem_out, 0);
            check("reset_rvalid", rvalid, 0);
            check("reset_rdata", rdata, 0);
        end else begin
            if (mem_out[32]) begin
                ops_seen++;
                act = {mem_out[56], mem_out[55:33], mem_out[31:0]};
                if (exp_ops.size() == 0) begin
                    fail("unexpected_sdram_op", act, 0);
                end else begin
                    e = exp_ops.pop_front();
                    if (!e[55]) act[31:0] = 32'h0;
                    check("sdram_op", act, e);
                end
            end
            if (rvalid) begin
                rv_seen++;
                last_rdata = rdata;
                if (exp_rd.size() == 0) fail("unexpected_rvalid", rdata, 0);
                else check("rdata", rdata, exp_rd.pop_front());
            end
        end
    end

    // SDRAM responder: reads return two cycles after acceptance.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (reset) begin
            rd_cnt = 0;
        end else begin
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = sdram[rd_word[1:0]];
                end
            end
            if (mem_out[32]) begin
                if (mem_out[56]) sdram[mem_out[34:33]] = mem_out[31:0];
                else begin
                    rd_word = mem_out[55:33];
                    rd_cnt  = 2;
                end
            end
        end
    end

    initial begin
        #200000;
        fail("global_timeout", 0, 1);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, o, r, held;
        reset = 1'b1; init = 1'b0; doit = 1'b0; addr = '0; wdata = 8'h00;
        wselect = 1'b0; mem_busy = 1'b0;

        // Reset clear: 4 zero writes then 3 settle cycles.
        push_clear();
        repeat (3) step();
        check("busy_in_reset", busy, 1);
        o = ops_seen;
        reset = 1'b0;
        wait_idle(n);
        check("reset_clear_cycles", n, 7);
        check("reset_clear_writes", ops_seen - o, 4);

        // Write A5 to addr 6 then read it back.
        req(4'd6, 1'b1, 8'hA5);
        wait_idle(n);
        check("word1_after_a5", sdram[1], 32'h0000A500);
        r = rv_seen;
        req(4'd6, 1'b0, 8'h00);
        wait_idle(n);
        check("rdata_a5", last_rdata, 8'hA5);
        check("rvalid_single_pulse", rv_seen - r, 1);

        // Fill word 0 byte by byte, read lanes back.
        req(4'd0, 1'b1, 8'h11);
        req(4'd1, 1'b1, 8'h22);
        req(4'd2, 1'b1, 8'h33);
        req(4'd3, 1'b1, 8'h44);
        req(4'd2, 1'b0, 8'h00);
        wait_idle(n);
        check("word0_merged", sdram[0], 32'h11223344);
        check("rdata_33", last_rdata, 8'h33);
        req(4'd0, 1'b0, 8'h00);
        wait_idle(n);
        check("rdata_11", last_rdata, 8'h11);

        // SDRAM busy held while RD_ISSUE; interpreter doit pulses ignored.
        mem_busy = 1'b1;
        o = ops_seen;
        r = rv_seen;
        req(4'd7, 1'b0, 8'h00);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_out[32]) held++;
            doit    = (i % 2 == 0);
            addr    = 4'd12;
            wselect = 1'b1;
            wdata   = 8'hFF;
            step();
        end
        doit = 1'b0;
        mem_busy = 1'b0;
        wait_idle(n);
        check("doit_low_while_busy", held, 0);
        check("single_read_after_busy", ops_seen - o, 1);
        check("rvalid_after_busy", rv_seen - r, 1);

        // init and doit together in IDLE: clear wins.
        wait_idle(n);
        push_clear();
        o = ops_seen;
        init = 1'b1; doit = 1'b1; addr = 4'd3; wselect = 1'b0;
        step();
        init = 1'b0; doit = 1'b0;
        wait_idle(n);
        check("init_priority_cycles", n, 7);
        check("init_priority_writes", ops_seen - o, 4);

        // init during SETTLE of a read: pending clear right after IDLE.
        req(4'd9, 1'b1, 8'h77);
        req(4'd9, 1'b0, 8'h00);
        n = 0;
        while (!rvalid && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) fail("rvalid_timeout", n, 0);
        check("rdata_77", rdata, 8'h77);
        push_clear();
        init = 1'b1;
        step();
        init = 1'b0;
        wait_idle(n);
        check("pending_clear_cycles", n, 10);
        req(4'd9, 1'b0, 8'h00);
        wait_idle(n);
        check("rdata_after_clear", last_rdata, 8'h00);

        // Reset while the read half of a write is outstanding.
        req(4'd10, 1'b1, 8'h5A);
        o = ops_seen;
        n = 0;
        while (ops_seen == o && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) fail("rmw_read_timeout", n, 0);
        exp_ops.delete();
        push_clear();
        reset = 1'b1;
        step();
        check("abort_busy", busy, 1);
        check("abort_rvalid", rvalid, 0);
        step();
        reset = 1'b0;
        wait_idle(n);
        check("abort_clear_cycles", n, 7);
        check("abort_word2", sdram[2], 32'h0);

        repeat (4) step();
        check("ops_queue_empty", exp_ops.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_lane_mem_adaptor.md
BYTE_LANE_MEM_ADAPTOR -- requirements
Module: byte_lane_mem_adaptor

Interface
REQ-001 SHALL have parameter LOGSIZE, default 10, byte-address width; legal range 3..25.
REQ-002 SHALL have parameter SETTLE, default 50, idle cycles enforced after every completed SDRAM operation; legal range 0..127.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill the memory after reset; 0 = go straight to IDLE.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 memOut  output  57  to SDRAM controller: [56] wselect, [55:33] word address, [32] doit, [31:0] write word.
REQ-007 memIn  input  34  from SDRAM controller: [33] busy, [32] rvalid, [31:0] read word.
REQ-008 init  input  1  request a zero-fill of the whole memory.
REQ-009 addr  input  LOGSIZE  byte address from the interpreter.
REQ-010 wdata  input  8  byte to write.
REQ-011 wselect  input  1  1 = write, 0 = read.
REQ-012 doit  input  1  request strobe.
REQ-013 busy  output  1  1 = adaptor cannot accept a request.
REQ-014 rvalid  output  1  one-cycle pulse when rdata carries a new read result.
REQ-015 rdata  output  8  result byte of the last completed read.

Function
REQ-016 SHALL map each byte address to word address addr[LOGSIZE-1:2], zero-extended to 23 bits, and to lane addr[1:0]; lane 0 = word bits [31:24], lane 3 = bits [7:0].
REQ-017 SHALL use states CLEAR, IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, SETTLE.
REQ-018 SHALL accept a request only when state is IDLE and doit=1, and SHALL latch addr, wdata and wselect on that edge; doit in any other state SHALL be ignored.
REQ-019 busy SHALL be 0 only in IDLE with no pending init.
REQ-020 Transition: IDLE with accepted request goes to RD_ISSUE; both reads and writes SHALL first read the whole word.
REQ-021 RD_ISSUE SHALL drive doit=1 and wselect=0 for exactly one cycle when memIn busy=0, then go to RD_WAIT; while memIn busy=1 it SHALL hold with doit=0.
REQ-022 RD_WAIT SHALL wait for memIn rvalid=1 and capture the read word on that cycle.
REQ-023 On that capture, a read SHALL load rdata with the selected lane, pulse rvalid on the following cycle, and go to SETTLE.
REQ-024 On that capture, a write SHALL merge wdata into the selected lane, keep the other three bytes, and go to WR_ISSUE.
REQ-025 Write reads SHALL never pulse rvalid or change rdata.
REQ-026 WR_ISSUE SHALL drive doit=1, wselect=1 and the merged word for one cycle when memIn busy=0, then go to SETTLE.
REQ-027 SETTLE SHALL load a counter with SETTLE, decrement once per cycle, and go to IDLE when the count reaches 0.
REQ-028 With SETTLE=0, the SETTLE state SHALL last exactly one cycle.
REQ-029 CLEAR SHALL write 32'h0 to word addresses 0 through 2^(LOGSIZE-2)-1 in ascending order, one write per cycle with memIn busy=0, with doit=1 and wselect=1 on each write.
REQ-030 CLEAR SHALL advance its word counter only on cycles where it issues a write.
REQ-031 After issuing the last word, CLEAR SHALL go to SETTLE; the counter SHALL not wrap.
REQ-032 init=1 in IDLE SHALL go to CLEAR; init=1 has priority over a simultaneous doit.
REQ-033 init=1 in any other state SHALL be held as pending and acted on at the next IDLE.
REQ-034 init=1 during CLEAR SHALL be ignored; it SHALL not restart the fill.
REQ-035 memOut doit SHALL be 0 in every state not named in REQ-021, REQ-026 and REQ-029.
REQ-036 memOut address and data SHALL be stable whenever memOut doit=1.

Reset
REQ-037 While reset=1, the adaptor SHALL immediately go to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
REQ-038 While reset=1: word counter=0, settle counter=0, pending init=0, rvalid=0, rdata=8'h00, memOut=0.
REQ-039 busy SHALL be 1 in reset when CLEAR_ON_RESET=1.
REQ-040 Reset during any operation SHALL abort it; a partially merged write SHALL not be issued.

Verification
REQ-041 Reset with LOGSIZE=4, SETTLE=2 -> exactly 4 zero writes to word addresses 0,1,2,3, then busy stays 1 for 3 SETTLE cycles, then busy=0.
REQ-042 Write 8'hA5 to addr 6, then read addr 6 -> one read of word 1, then a write of 32'h0000A500; the read returns rdata=8'hA5 with a single rvalid pulse.
REQ-043 Write 8'h11, 8'h22, 8'h33, 8'h44 to addrs 0..3, then read addr 2 -> word 0 = 32'h11223344; rdata=8'h33.
REQ-044 Hold memIn busy=1 for 5 cycles during RD_ISSUE -> memOut doit stays 0 until busy falls, then pulses exactly once; doit pulses from the interpreter meanwhile are ignored.
REQ-045 Assert init during the SETTLE of a read -> the full CLEAR sequence starts on the cycle after IDLE is reached; a following read of any address returns 8'h00.
REQ-046 Assert reset while in RD_WAIT of a write -> no write is issued; state CLEAR (or IDLE); rvalid=0.
